// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings and the receive/transmit FSM state set.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Double-register the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with a single-entry holding register and valid/ready output.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uartRx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             ODD_SEL   = 1'(PARITY == PAR_ODD);

  logic                 w_rx;
  logic                 w_par_err;

  uart_state_t          r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [3:0]           r_bit;
  logic                 r_stop;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_ferr_acc;
  logic                 r_done;

  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_overrun;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (uartRx),
    .o_q  (w_rx)
  );

  // Received parity bit versus the data XOR; odd parity expects the inverted XOR.
  assign w_par_err = w_rx ^ (^r_shift) ^ ODD_SEL;

  // Frame FSM: mid-bit sampling; returns to IDLE at the last stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_stop     <= 1'b0;
      r_shift    <= '0;
      r_par_err  <= 1'b0;
      r_ferr_acc <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_rx) begin
            r_state <= ST_START;
            r_cnt   <= '0;
          end
        end
        ST_START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt <= '0;
            if (w_rx) begin
              r_state <= ST_IDLE;
            end else begin
              r_state    <= ST_DATA;
              r_bit      <= '0;
              r_ferr_acc <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (r_cnt == CNT_FULL) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
            if (r_bit == BIT_LAST) begin
              r_state <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
              r_stop  <= 1'b0;
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_PAR: begin
          if (r_cnt == CNT_FULL) begin
            r_cnt     <= '0;
            r_par_err <= w_par_err;
            r_state   <= ST_STOP;
            r_stop    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (r_cnt == CNT_FULL) begin
            r_cnt <= '0;
            if (!w_rx) begin
              r_ferr_acc <= 1'b1;
            end
            if (r_stop == STOP_LAST) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_stop <= r_stop + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Holding register: load on frame completion unless full and not being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_done) begin
        if (r_rx_valid && !rx_ready) begin
          r_overrun <= 1'b1;
        end else begin
          r_rx_data    <= r_shift;
          r_parity_err <= r_par_err;
          r_frame_err  <= r_ferr_acc;
          r_rx_valid   <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: three configurations, table-driven frames plus corner sequences.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int unsigned CPB = 16;

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  typedef struct {
    int         id;
    logic [8:0] data;
    logic       par_wrong;
    logic [1:0] stop_low;
    logic [8:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] rx_line = '1;
  logic [2:0] ready = '1;
  logic [7:0] d0;
  logic [6:0] d1, d2;
  logic       vld0, vld1, vld2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2;
  logic [8:0] dat [3];
  logic [2:0] vld, perr, ferr, ovr;

  exp_t q0[$], q1[$], q2[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   ovr_cnt[3] = '{0, 0, 0};
  bit   hs_prev[3] = '{0, 0, 0};
  vec_t vt[11];

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .uartRx(rx_line[0]), .rx_data(d0), .rx_valid(vld0),
    .rx_ready(ready[0]), .parity_err(pe0), .frame_err(fe0), .overrun(ov0));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .uartRx(rx_line[1]), .rx_data(d1), .rx_valid(vld1),
    .rx_ready(ready[1]), .parity_err(pe1), .frame_err(fe1), .overrun(ov1));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_ODD), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .uartRx(rx_line[2]), .rx_data(d2), .rx_valid(vld2),
    .rx_ready(ready[2]), .parity_err(pe2), .frame_err(fe2), .overrun(ov2));

  assign dat[0] = {1'b0, d0};
  assign dat[1] = {2'b0, d1};
  assign dat[2] = {2'b0, d2};
  assign vld  = {vld2, vld1, vld0};
  assign perr = {pe2, pe1, pe0};
  assign ferr = {fe2, fe1, fe0};
  assign ovr  = {ov2, ov1, ov0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic pop_compare(input int id);
    exp_t e;
    bit   got = 0;
    case (id)
      0: if (q0.size() != 0) begin e = q0.pop_front(); got = 1; end
      1: if (q1.size() != 0) begin e = q1.pop_front(); got = 1; end
      default: if (q2.size() != 0) begin e = q2.pop_front(); got = 1; end
    endcase
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame%0d_unexpected: got data %0h, expected no frame", id, dat[id]);
    end else begin
      check($sformatf("frame%0d {data,pe,fe}", id), {21'd0, dat[id], perr[id], ferr[id]},
            {21'd0, e.data, e.pe, e.fe});
    end
  endtask

  task automatic push_exp(input int id, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d; e.pe = pe; e.fe = fe;
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Scoreboard monitor: sample away from the rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_n) begin
        if (ovr[i]) ovr_cnt[i]++;
        if (hs_prev[i]) check($sformatf("valid_drop%0d", i), {31'd0, vld[i]}, 32'd0);
        hs_prev[i] = vld[i] && ready[i];
        if (vld[i] && ready[i]) pop_compare(i);
      end else begin
        hs_prev[i] = 0;
      end
    end
  end

  task automatic wait_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input int id, input logic [8:0] data, input logic par_wrong,
                            input logic [1:0] stop_low);
    int   nbits;
    int   nstop;
    logic p;
    nbits = (id == 0) ? 8 : 7;
    nstop = (id == 2) ? 2 : 1;
    rx_line[id] = 1'b0;
    wait_bits(1);
    p = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      rx_line[id] = data[i];
      p = p ^ data[i];
      wait_bits(1);
    end
    if (id != 0) begin
      if (id == 2) p = ~p;
      if (par_wrong) p = ~p;
      rx_line[id] = p;
      wait_bits(1);
    end
    for (int s = 0; s < nstop; s++) begin
      rx_line[id] = ~stop_low[s];
      wait_bits(1);
    end
    rx_line[id] = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("drain_pending", q0.size() + q1.size() + q2.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s_out%0d", tag, i),
            {19'd0, dat[i], vld[i], perr[i], ferr[i], ovr[i]}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{0, 9'h0A5, 1'b0, 2'b00, 9'h0A5, 1'b0, 1'b0};
    vt[1]  = '{0, 9'h000, 1'b0, 2'b00, 9'h000, 1'b0, 1'b0};
    vt[2]  = '{0, 9'h0FF, 1'b0, 2'b00, 9'h0FF, 1'b0, 1'b0};
    vt[3]  = '{1, 9'h035, 1'b1, 2'b00, 9'h035, 1'b1, 1'b0};
    vt[4]  = '{1, 9'h035, 1'b0, 2'b00, 9'h035, 1'b0, 1'b0};
    vt[5]  = '{1, 9'h07F, 1'b0, 2'b00, 9'h07F, 1'b0, 1'b0};
    vt[6]  = '{2, 9'h035, 1'b0, 2'b00, 9'h035, 1'b0, 1'b0};
    vt[7]  = '{2, 9'h03C, 1'b0, 2'b10, 9'h03C, 1'b0, 1'b1};
    vt[8]  = '{2, 9'h012, 1'b0, 2'b00, 9'h012, 1'b0, 1'b0};
    vt[9]  = '{2, 9'h055, 1'b1, 2'b00, 9'h055, 1'b1, 1'b0};
    vt[10] = '{0, 9'h03C, 1'b0, 2'b01, 9'h03C, 1'b0, 1'b1};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int v = 0; v < 11; v++) begin
      push_exp(vt[v].id, vt[v].exp_data, vt[v].exp_pe, vt[v].exp_fe);
      send_frame(vt[v].id, vt[v].data, vt[v].par_wrong, vt[v].stop_low);
      wait_bits(2);
    end
    wait_drain(500);

    // Short low glitch must not produce a frame; the next frame is intact.
    rx_line[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx_line[0] = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_valid", {31'd0, vld0}, 32'd0);
    push_exp(0, 9'h055, 1'b0, 1'b0);
    send_frame(0, 9'h055, 1'b0, 2'b00);
    wait_bits(2);
    wait_drain(200);

    // Overrun: hold off the consumer across two back-to-back frames.
    @(posedge clk);
    #1 ready[0] = 1'b0;
    push_exp(0, 9'h011, 1'b0, 1'b0);
    send_frame(0, 9'h011, 1'b0, 2'b00);
    send_frame(0, 9'h022, 1'b0, 2'b00);
    repeat (20) @(negedge clk);
    check("ovr_pulses", ovr_cnt[0], 32'd1);
    check("ovr_held_valid", {31'd0, vld0}, 32'd1);
    check("ovr_held_data", {24'd0, d0}, 32'h11);
    @(posedge clk);
    #1 ready[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("ovr_valid_cleared", {31'd0, vld0}, 32'd0);
    wait_drain(10);

    // Reset in the middle of 0xFF's data bits abandons that frame.
    rx_line[0] = 1'b0;
    wait_bits(1);
    rx_line[0] = 1'b1;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    push_exp(0, 9'h081, 1'b0, 1'b0);
    send_frame(0, 9'h081, 1'b0, 2'b00);
    wait_bits(2);
    wait_drain(200);

    check("ovr_total0", ovr_cnt[0], 32'd1);
    check("ovr_total1", ovr_cnt[1], 32'd0);
    check("ovr_total2", ovr_cnt[2], 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
